tnoc_flit_unpacker: RTL and testbench

Receive-side endpoint stage that consumes the flit stream leaving a router's local port and rebuilds packets from it. It collects the header flits into one registered header word, hands that word to the endpoint over a header channel, and then forwards payload flits over a payload channel until the packet's tail flit. It also checks flit framing and flags malformed flits.

---
 rtl/tnoc_flit_unpacker.sv | 193 +++++++++++++++++++
 tb/tb_tnoc_flit_unpacker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tnoc_flit_unpacker.sv
// Receive-side NoC endpoint: rebuilds packets from the local-port flit stream.
// Header flits are assembled into one word, payload flits pass straight through.
module tnoc_flit_unpacker #(
  parameter int FLIT_DATA_WIDTH = 64,
  parameter int HEADER_WIDTH    = 100
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flit_valid,
  output logic                       o_flit_ready,
  input  logic [FLIT_DATA_WIDTH+2:0] i_flit,
  output logic                       o_header_valid,
  input  logic                       i_header_ready,
  output logic [HEADER_WIDTH-1:0]    o_header,
  output logic                       o_payload_valid,
  input  logic                       i_payload_ready,
  output logic [FLIT_DATA_WIDTH-1:0] o_payload,
  output logic                       o_payload_last,
  output logic                       o_error
);

  localparam int HEADER_FLITS =
    (HEADER_WIDTH + FLIT_DATA_WIDTH - 1) / FLIT_DATA_WIDTH;
  localparam int CAT_W = HEADER_FLITS * FLIT_DATA_WIDTH;
  localparam int CNT_W = (HEADER_FLITS > 1) ? $clog2(HEADER_FLITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HEADER_FLITS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_HDR     = 2'd2;
  localparam logic [1:0] S_PAYLOAD = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CAT_W-1:0]        buf_q, buf_d;
  logic [HEADER_WIDTH-1:0] hdr_q, hdr_d;
  logic                    hp_q, hp_d;

  logic [FLIT_DATA_WIDTH-1:0] f_data;
  logic                       f_tail;
  logic                       f_head;
  logic                       f_pay;
  logic                       f_hp;

  assign f_data = i_flit[FLIT_DATA_WIDTH+2:3];
  assign f_tail = i_flit[2];
  assign f_head = i_flit[1];
  assign f_pay  = i_flit[0];
  assign f_hp   = i_flit[FLIT_DATA_WIDTH+1];

  logic [CAT_W-1:0] cat_first;
  logic [CAT_W-1:0] cat_shift;
  logic [CAT_W-1:0] fin_cat;
  logic             fin;
  logic             fin_hp;
  logic             err;
  logic             ready;
  logic             hv;
  logic             pv;
  logic             plast;

  // Flit 0 enters at the LSBs and is shifted up, ending in the MSBs.
  assign cat_first = CAT_W'(f_data);
  assign cat_shift = (buf_q << FLIT_DATA_WIDTH) | CAT_W'(f_data);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    hdr_d   = hdr_q;
    hp_d    = hp_q;
    fin     = 1'b0;
    fin_cat = '0;
    fin_hp  = 1'b0;
    err     = 1'b0;
    ready   = 1'b0;
    hv      = 1'b0;
    pv      = 1'b0;
    plast   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (i_flit_valid) begin
          if (!f_pay && f_head) begin
            buf_d = cat_first;
            hp_d  = f_hp;
            if (LAST_IDX == '0) begin
              fin     = 1'b1;
              fin_cat = cat_first;
              fin_hp  = f_hp;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = S_COLLECT;
            end
          end else begin
            err = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        ready = 1'b1;
        if (i_flit_valid) begin
          if (f_pay) begin
            err     = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else if (f_head) begin
            err   = 1'b1;
            buf_d = cat_first;
            hp_d  = f_hp;
            if (LAST_IDX == '0) begin
              fin     = 1'b1;
              fin_cat = cat_first;
              fin_hp  = f_hp;
            end else begin
              cnt_d = CNT_W'(1);
            end
          end else if (cnt_q == LAST_IDX) begin
            buf_d   = cat_shift;
            fin     = 1'b1;
            fin_cat = cat_shift;
            fin_hp  = hp_q;
          end else if (f_tail) begin
            err     = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            buf_d = cat_shift;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_HDR: begin
        hv = 1'b1;
        if (i_header_ready) begin
          state_d = hp_q ? S_PAYLOAD : S_IDLE;
        end
      end
      S_PAYLOAD: begin
        pv    = i_flit_valid;
        ready = i_payload_ready;
        plast = f_tail;
        if (i_flit_valid && i_payload_ready) begin
          if (!f_pay || f_head) begin
            err = 1'b1;
          end
          if (f_tail) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A tail that disagrees with has_payload is flagged; tail=1 ends the packet.
    if (fin) begin
      hdr_d   = fin_cat[CAT_W-1 -: HEADER_WIDTH];
      hp_d    = fin_hp;
      cnt_d   = '0;
      state_d = S_HDR;
      if (f_tail == fin_hp) begin
        err = 1'b1;
        if (f_tail) begin
          hp_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      hdr_q   <= '0;
      hp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      hdr_q   <= hdr_d;
      hp_q    <= hp_d;
    end
  end

  assign o_flit_ready    = ready;
  assign o_header_valid  = hv;
  assign o_header        = hdr_q;
  assign o_payload_valid = pv;
  assign o_payload       = f_data;
  assign o_payload_last  = plast;
  assign o_error         = err;

endmodule

// File: tb/tb_tnoc_flit_unpacker.sv
// Directed bench for tnoc_flit_unpacker at default parameters.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_tnoc_flit_unpacker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fv = 1'b0;
  logic        fr;
  logic [66:0] fl = '0;
  logic        hv;
  logic        hr = 1'b0;
  logic [99:0] hdr;
  logic        pv;
  logic        pr = 1'b0;
  logic [63:0] pl;
  logic        plast;
  logic        err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tnoc_flit_unpacker dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_flit_valid    (fv),
    .o_flit_ready    (fr),
    .i_flit          (fl),
    .o_header_valid  (hv),
    .i_header_ready  (hr),
    .o_header        (hdr),
    .o_payload_valid (pv),
    .i_payload_ready (pr),
    .o_payload       (pl),
    .o_payload_last  (plast),
    .o_error         (err)
  );

  function automatic logic [66:0] mk(input logic [63:0] d, input logic t,
                                     input logic h, input logic ty);
    return {d, t, h, ty};
  endfunction

  task automatic drv(input logic v, input logic [66:0] f,
                     input logic h, input logic p);
    @(negedge clk);
    fv = v; fl = f; hr = h; pr = p;
    #1;
  endtask

  localparam logic [63:0] PW0 = 64'h40A1_B2C3_D4E5_F607;
  localparam logic [63:0] PW1 = 64'h1122_3344_5566_7788;
  localparam logic [99:0] PW_HDR = 100'h40A1B2C3D4E5F607112233445;
  localparam logic [63:0] RD0 = 64'h2012_3456_789A_BCDE;
  localparam logic [63:0] RD1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [99:0] RD_HDR = 100'h20123456789ABCDEFEDCBA987;
  localparam logic [63:0] PA = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] PB = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] PC = 64'hCCCC_0000_0000_0003;

  task automatic test_reset();
    drv(0, '0, 0, 0);
    drv(0, '0, 0, 0);
    total++; if (hv !== 1'b0) begin bad++; $display("FAIL rst_hv got=%b exp=0", hv); end
    total++; if (hdr !== '0) begin bad++; $display("FAIL rst_hdr got=%h exp=0", hdr); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    total++; if (pv !== 1'b0) begin bad++; $display("FAIL rst_pv got=%b exp=0", pv); end
    total++; if (plast !== 1'b0) begin bad++; $display("FAIL rst_last got=%b exp=0", plast); end
    total++; if (fr !== 1'b1) begin bad++; $display("FAIL rst_fr got=%b exp=1", fr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_posted_write();
    drv(1, mk(PW0, 0, 1, 0), 1, 1);
    total++; if (fr !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL pw_f0 got fr=%b err=%b exp 1 0", fr, err); end
    drv(1, mk(PW1, 0, 0, 0), 1, 1);
    total++; if (hv !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL pw_f1 got hv=%b err=%b exp 0 0", hv, err); end
    drv(0, '0, 1, 1);
    total++; if (hv !== 1'b1) begin bad++; $display("FAIL pw_hv got=%b exp=1", hv); end
    total++; if (hdr !== PW_HDR) begin bad++; $display("FAIL pw_hdr got=%h exp=%h", hdr, PW_HDR); end
    total++; if (fr !== 1'b0) begin bad++; $display("FAIL pw_hdr_fr got=%b exp=0", fr); end
    drv(1, mk(PA, 0, 0, 1), 1, 1);
    total++; if (pv !== 1'b1 || pl !== PA || plast !== 1'b0) begin bad++; $display("FAIL pw_a got pv=%b pl=%h last=%b exp 1 %h 0", pv, pl, plast, PA); end
    drv(1, mk(PB, 0, 0, 1), 1, 1);
    total++; if (pv !== 1'b1 || pl !== PB || plast !== 1'b0) begin bad++; $display("FAIL pw_b got pv=%b pl=%h last=%b exp 1 %h 0", pv, pl, plast, PB); end
    drv(1, mk(PC, 1, 0, 1), 1, 1);
    total++; if (pv !== 1'b1 || pl !== PC || plast !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL pw_c got pv=%b pl=%h last=%b err=%b exp 1 %h 1 0", pv, pl, plast, err, PC); end
    drv(0, '0, 0, 0);
    total++; if (pv !== 1'b0 || fr !== 1'b1) begin bad++; $display("FAIL pw_idle got pv=%b fr=%b exp 0 1", pv, fr); end
  endtask

  task automatic test_read();
    drv(1, mk(RD0, 0, 1, 0), 1, 1);
    drv(1, mk(RD1, 1, 0, 0), 1, 1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rd_tail_err got=%b exp=0", err); end
    drv(0, '0, 1, 1);
    total++; if (hv !== 1'b1 || hdr !== RD_HDR) begin bad++; $display("FAIL rd_hdr got hv=%b hdr=%h exp 1 %h", hv, hdr, RD_HDR); end
    total++; if (pv !== 1'b0) begin bad++; $display("FAIL rd_pv got=%b exp=0", pv); end
    drv(1, mk(PW0, 0, 1, 0), 1, 0);
    total++; if (fr !== 1'b1 || err !== 1'b0 || hv !== 1'b0) begin bad++; $display("FAIL rd_next_f0 got fr=%b err=%b hv=%b exp 1 0 0", fr, err, hv); end
    drv(1, mk(PW1, 0, 0, 0), 1, 0);
    drv(0, '0, 1, 0);
    total++; if (hv !== 1'b1 || hdr !== PW_HDR) begin bad++; $display("FAIL rd_next_hdr got hv=%b hdr=%h exp 1 %h", hv, hdr, PW_HDR); end
    drv(1, mk(PA, 1, 0, 1), 0, 1);
    total++; if (pv !== 1'b1 || plast !== 1'b1) begin bad++; $display("FAIL rd_next_pl got pv=%b last=%b exp 1 1", pv, plast); end
  endtask

  task automatic test_backpressure();
    logic [63:0] pd [3];
    int idx;
    logic p;
    pd[0] = PA; pd[1] = PB; pd[2] = PC;
    idx = 0;
    drv(1, mk(PW0, 0, 1, 0), 0, 0);
    drv(1, mk(PW1, 0, 0, 0), 0, 0);
    for (int c = 0; c < 5; c++) begin
      drv(1, mk(PA, 0, 0, 1), 0, 0);
      total++; if (hv !== 1'b1 || fr !== 1'b0 || hdr !== PW_HDR) begin bad++; $display("FAIL bp_hold%0d got hv=%b fr=%b hdr=%h exp 1 0 %h", c, hv, fr, hdr, PW_HDR); end
    end
    drv(1, mk(PA, 0, 0, 1), 1, 0);
    for (int c = 0; c < 5; c++) begin
      p = (c % 2 == 0);
      drv(1, mk(pd[idx], idx == 2, 0, 1), 0, p);
      total++; if (pv !== 1'b1 || pl !== pd[idx] || fr !== p || plast !== (idx == 2)) begin bad++; $display("FAIL bp_pl%0d got pv=%b pl=%h fr=%b last=%b exp 1 %h %b %b", c, pv, pl, fr, plast, pd[idx], p, idx == 2); end
      if (p) idx++;
    end
    drv(0, '0, 0, 0);
    total++; if (fr !== 1'b1 || hdr !== PW_HDR) begin bad++; $display("FAIL bp_end got fr=%b hdr=%h exp 1 %h", fr, hdr, PW_HDR); end
  endtask

  task automatic test_errors();
    drv(1, mk(PA, 0, 0, 1), 0, 0);
    total++; if (err !== 1'b1 || fr !== 1'b1 || pv !== 1'b0) begin bad++; $display("FAIL er_idle_pl got err=%b fr=%b pv=%b exp 1 1 0", err, fr, pv); end
    drv(0, '0, 0, 0);
    total++; if (err !== 1'b0 || hv !== 1'b0 || fr !== 1'b1) begin bad++; $display("FAIL er_idle_after got err=%b hv=%b fr=%b exp 0 0 1", err, hv, fr); end
    drv(1, mk(RD0, 0, 1, 0), 0, 0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL er_rs_f0 got=%b exp=0", err); end
    drv(1, mk(64'h4F00_0000_0000_0001, 0, 1, 0), 0, 0);
    total++; if (err !== 1'b1 || fr !== 1'b1) begin bad++; $display("FAIL er_restart got err=%b fr=%b exp 1 1", err, fr); end
    drv(1, mk(64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0), 0, 0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL er_rs_f1 got=%b exp=0", err); end
    drv(0, '0, 1, 0);
    total++; if (hv !== 1'b1 || hdr !== 100'h4F00000000000001AAAABBBBC) begin bad++; $display("FAIL er_rs_hdr got hv=%b hdr=%h exp 1 4f00000000000001aaaabbbbc", hv, hdr); end
    drv(1, mk(PB, 1, 0, 1), 0, 1);
    total++; if (pv !== 1'b1 || pl !== PB || err !== 1'b0) begin bad++; $display("FAIL er_rs_pl got pv=%b pl=%h err=%b exp 1 %h 0", pv, pl, err, PB); end
    drv(1, mk(PW0, 0, 1, 0), 0, 0);
    drv(1, mk(PW1, 1, 0, 0), 0, 0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL er_tail got=%b exp=1", err); end
    drv(0, '0, 1, 0);
    total++; if (hv !== 1'b1 || err !== 1'b0 || hdr !== PW_HDR) begin bad++; $display("FAIL er_tail_hdr got hv=%b err=%b hdr=%h exp 1 0 %h", hv, err, hdr, PW_HDR); end
    drv(0, '0, 0, 0);
    total++; if (fr !== 1'b1 || hv !== 1'b0) begin bad++; $display("FAIL er_tail_idle got fr=%b hv=%b exp 1 0", fr, hv); end
  endtask

  task automatic test_reset_mid_payload();
    drv(1, mk(PW0, 0, 1, 0), 0, 0);
    drv(1, mk(PW1, 0, 0, 0), 0, 0);
    drv(0, '0, 1, 0);
    drv(1, mk(PA, 0, 0, 1), 0, 1);
    total++; if (pv !== 1'b1 || pl !== PA) begin bad++; $display("FAIL rm_a got pv=%b pl=%h exp 1 %h", pv, pl, PA); end
    @(negedge clk);
    rst_n = 1'b0; fv = 1'b0; pr = 1'b0; hr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (hv !== 1'b0 || err !== 1'b0 || fr !== 1'b1 || pv !== 1'b0) begin bad++; $display("FAIL rm_idle got hv=%b err=%b fr=%b pv=%b exp 0 0 1 0", hv, err, fr, pv); end
    total++; if (hdr !== '0) begin bad++; $display("FAIL rm_hdr got=%h exp=0", hdr); end
    drv(1, mk(RD0, 0, 1, 0), 0, 0);
    drv(1, mk(RD1, 1, 0, 0), 0, 0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rm_f1 got=%b exp=0", err); end
    drv(0, '0, 1, 0);
    total++; if (hv !== 1'b1 || hdr !== RD_HDR) begin bad++; $display("FAIL rm_hdr2 got hv=%b hdr=%h exp 1 %h", hv, hdr, RD_HDR); end
    drv(0, '0, 0, 0);
    total++; if (fr !== 1'b1 || hv !== 1'b0) begin bad++; $display("FAIL rm_end got fr=%b hv=%b exp 1 0", fr, hv); end
  endtask

  initial begin
    test_reset();
    test_posted_write();
    test_read();
    test_backpressure();
    test_errors();
    test_reset_mid_payload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
